// File: rtl/tetris_move_sched.sv
// -----------------------------------------------------------------------------
// tetris_move_sched
//
// Sequences piece-motion commands into the playfield engine. A gravity timer
// raises FALL requests at a normal or fast-drop period, button releases raise
// LEFT/RIGHT/ROTATE requests, and pending requests are issued one at a time by
// fixed priority (FALL > ROTATE > LEFT > RIGHT) over a valid/ready/done
// handshake. A FALL that completes blocked is reported as a lock event.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   enable          game running; low blocks new requests and issue
//   btn_left/right/rotate, sw_drop   level inputs, acted on at release
//   cmd_valid/cmd_op                 command offer (0 NONE,1 FALL,2 LEFT,
//                                    3 RIGHT,4 ROTATE)
//   cmd_ready/cmd_done/cmd_blocked   engine handshake and completion status
//   fast_mode       fast-drop gravity active
//   pending         live request flags {rotate, right, left, fall}
//   lock_event      one-cycle pulse: FALL completed blocked
// -----------------------------------------------------------------------------
module tetris_move_sched #(
   parameter int unsigned FALL_PERIOD = 50000000,
   parameter int unsigned DROP_PERIOD = 5000000,
   parameter int unsigned CNT_W       = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_rotate,
   input  logic       sw_drop,
   output logic       cmd_valid,
   output logic [2:0] cmd_op,
   input  logic       cmd_ready,
   input  logic       cmd_done,
   input  logic       cmd_blocked,
   output logic       fast_mode,
   output logic [3:0] pending,
   output logic       lock_event
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   localparam logic [2:0] OP_NONE   = 3'd0;
   localparam logic [2:0] OP_FALL   = 3'd1;
   localparam logic [2:0] OP_LEFT   = 3'd2;
   localparam logic [2:0] OP_RIGHT  = 3'd3;
   localparam logic [2:0] OP_ROTATE = 3'd4;

   localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_PERIOD - 1);
   localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_PERIOD - 1);

   state_t           state_q;
   logic [3:0]       hist_q;       // previous input levels {drop, rotate, right, left}
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fast_q, fast_d;
   logic [3:0]       pend_q, pend_d;
   logic             valid_q;
   logic [2:0]       op_q;
   logic             lock_q, lock_d;

   logic [3:0]       cur_in;
   logic [3:0]       ev;
   logic [CNT_W-1:0] per_last;
   logic             tick;
   logic [2:0]       sel_op;
   logic [3:0]       sel_mask;

   always_comb begin
      cur_in   = {sw_drop, btn_rotate, btn_right, btn_left};
      // Release = was high last cycle, low now; ignored while the game is stopped.
      ev       = enable ? (hist_q & ~cur_in) : 4'b0000;

      per_last = fast_q ? DROP_LAST : FALL_LAST;
      // >= rather than == so a switch into fast mode with a large count
      // ticks on the very next cycle instead of running to wrap-around.
      tick     = enable && (cnt_q >= per_last);
      cnt_d    = (!enable || tick) ? '0 : cnt_q + 1'b1;

      sel_op   = OP_NONE;
      sel_mask = 4'b0000;
      if (state_q == S_IDLE && enable) begin
         if (pend_q[0]) begin
            sel_op   = OP_FALL;
            sel_mask = 4'b0001;
         end else if (pend_q[3]) begin
            sel_op   = OP_ROTATE;
            sel_mask = 4'b1000;
         end else if (pend_q[1]) begin
            sel_op   = OP_LEFT;
            sel_mask = 4'b0010;
         end else if (pend_q[2]) begin
            sel_op   = OP_RIGHT;
            sel_mask = 4'b0100;
         end
      end

      lock_d = (state_q == S_WAIT) && cmd_done && cmd_blocked && (op_q == OP_FALL);

      // Set is OR-ed in after the clear so a same-cycle set wins.
      pend_d = enable ? ((pend_q & ~sel_mask) | {ev[2], ev[1], ev[0], tick}) : 4'b0000;

      if (!enable)     fast_d = 1'b0;
      else if (lock_d) fast_d = 1'b0;
      else if (ev[3])  fast_d = 1'b1;
      else             fast_d = fast_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         hist_q  <= 4'b0000;
         cnt_q   <= '0;
         fast_q  <= 1'b0;
         pend_q  <= 4'b0000;
         valid_q <= 1'b0;
         op_q    <= OP_NONE;
         lock_q  <= 1'b0;
      end else begin
         hist_q  <= cur_in;
         cnt_q   <= cnt_d;
         fast_q  <= fast_d;
         pend_q  <= pend_d;
         lock_q  <= lock_d;
         // The handshake always runs to completion; enable only gates issue.
         case (state_q)
            S_IDLE: begin
               if (sel_op != OP_NONE) begin
                  op_q    <= sel_op;
                  valid_q <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_ready) begin
                  valid_q <= 1'b0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cmd_done) begin
                  op_q    <= OP_NONE;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               op_q    <= OP_NONE;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_valid  = valid_q;
   assign cmd_op     = op_q;
   assign fast_mode  = fast_q;
   assign pending    = pend_q;
   assign lock_event = lock_q;

endmodule

// File: tb/tb_tetris_move_sched.sv
module tb_tetris_move_sched;
   localparam int FALL = 10;
   localparam int DROP = 3;

   logic       clk = 1'b0;
   logic       rst, enable, btn_left, btn_right, btn_rotate, sw_drop;
   logic       cmd_ready, cmd_done, cmd_blocked;
   logic       cmd_valid, fast_mode, lock_event;
   logic [2:0] cmd_op;
   logic [3:0] pending;

   int n_checks = 0;
   int n_fail   = 0;
   bit auto_eng = 0;
   bit eng_blocked = 0;
   int eng_cd = 0;

   always #5 clk = ~clk;

   tetris_move_sched #(.FALL_PERIOD(FALL), .DROP_PERIOD(DROP), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .enable(enable), .btn_left(btn_left), .btn_right(btn_right),
      .btn_rotate(btn_rotate), .sw_drop(sw_drop), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_blocked(cmd_blocked),
      .fast_mode(fast_mode), .pending(pending), .lock_event(lock_event));

   // Reference model: request flags indexed 0 fall, 1 left, 2 right, 3 rotate;
   // phase 0 idle, 1 offering, 2 awaiting done.
   int       m_cnt = 0;
   bit       m_fast = 0;
   bit [3:0] m_pend = 0;
   int       m_phase = 0;
   bit       m_valid = 0;
   int       m_op = 0;
   bit       m_lock = 0;
   bit       m_h_l = 0, m_h_r = 0, m_h_rot = 0, m_h_drop = 0;

   always @(posedge clk) begin
      bit ev_l, ev_r, ev_rot, ev_drop, tk, lk;
      int per, sel;
      if (rst) begin
         m_cnt = 0; m_fast = 0; m_pend = 0; m_phase = 0; m_valid = 0; m_op = 0; m_lock = 0;
         m_h_l = 0; m_h_r = 0; m_h_rot = 0; m_h_drop = 0;
      end else begin
         ev_l = m_h_l && !btn_left;
         ev_r = m_h_r && !btn_right;
         ev_rot = m_h_rot && !btn_rotate;
         ev_drop = m_h_drop && !sw_drop;
         m_h_l = btn_left; m_h_r = btn_right; m_h_rot = btn_rotate; m_h_drop = sw_drop;
         per = m_fast ? DROP : FALL;
         tk = enable && (m_cnt >= per - 1);
         m_cnt = (!enable || tk) ? 0 : m_cnt + 1;
         lk = (m_phase == 2) && cmd_done && cmd_blocked && (m_op == 1);
         m_lock = lk;
         sel = -1;
         if (m_phase == 0 && enable) begin
            if (m_pend[0]) sel = 0;
            else if (m_pend[3]) sel = 3;
            else if (m_pend[1]) sel = 1;
            else if (m_pend[2]) sel = 2;
         end
         if (!enable) m_pend = 0;
         else begin
            if (sel >= 0) m_pend[sel] = 0;
            if (tk) m_pend[0] = 1;
            if (ev_l) m_pend[1] = 1;
            if (ev_r) m_pend[2] = 1;
            if (ev_rot) m_pend[3] = 1;
         end
         if (!enable) m_fast = 0;
         else if (lk) m_fast = 0;
         else if (ev_drop) m_fast = 1;
         case (m_phase)
            0: if (sel >= 0) begin
               m_valid = 1;
               m_op = (sel == 0) ? 1 : (sel == 1) ? 2 : (sel == 2) ? 3 : 4;
               m_phase = 1;
            end
            1: if (cmd_ready) begin m_valid = 0; m_phase = 2; end
            default: if (cmd_done) begin m_op = 0; m_phase = 0; end
         endcase
      end
   end

   // Advance to the next falling edge; optionally act as an engine that
   // accepts immediately and finishes two cycles after acceptance.
   task automatic step();
      @(negedge clk);
      if (auto_eng) begin
         cmd_ready = 1; cmd_done = 0; cmd_blocked = 0;
         if (eng_cd > 0) begin
            eng_cd--;
            if (eng_cd == 0) begin cmd_done = 1; cmd_blocked = eng_blocked; end
         end
         if (cmd_valid && cmd_ready) eng_cd = 2;
      end
   endtask

   task automatic do_reset();
      rst = 1; enable = 0; cmd_ready = 0; cmd_done = 0; cmd_blocked = 0; eng_cd = 0;
      btn_left = 0; btn_right = 0; btn_rotate = 0; sw_drop = 0;
      step(); step();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; enable = 1; btn_left = 0; btn_right = 0; btn_rotate = 0; sw_drop = 0;
      cmd_ready = 0; cmd_done = 0; cmd_blocked = 0;
      step(); step();
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
      n_checks++; if (cmd_op !== 3'd0) begin n_fail++; $display("FAIL reset_op: got %0d want 0", cmd_op); end
      n_checks++; if (fast_mode !== 1'b0) begin n_fail++; $display("FAIL reset_fast: got %b want 0", fast_mode); end
      n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", pending); end
      n_checks++; if (lock_event !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b want 0", lock_event); end
      rst = 0;
   endtask

   task automatic test_gravity();
      int last = -1;
      int rises = 0;
      bit pv = 0;
      do_reset();
      auto_eng = 1; eng_blocked = 0; enable = 1;
      for (int c = 0; c < 50; c++) begin
         step();
         if (cmd_valid && !pv) begin
            n_checks++; if (cmd_op !== 3'd1) begin n_fail++; $display("FAIL grav_op: got %0d want 1", cmd_op); end
            if (last < 0) begin
               n_checks++; if (c != 10) begin n_fail++; $display("FAIL grav_first: got cycle %0d want 10", c); end
            end else begin
               n_checks++; if (c - last != FALL) begin n_fail++; $display("FAIL grav_period: got %0d want %0d", c - last, FALL); end
            end
            last = c; rises++;
         end
         pv = cmd_valid;
      end
      n_checks++; if (rises < 4) begin n_fail++; $display("FAIL grav_count: got %0d want >=4", rises); end
      n_checks++; if (fast_mode !== 1'b0) begin n_fail++; $display("FAIL grav_fast: got %b want 0", fast_mode); end
   endtask

   task automatic test_left_rotate();
      int ops[$];
      bit pv;
      btn_left = 1; btn_rotate = 1;
      step(); step();
      btn_left = 0; btn_rotate = 0;
      pv = cmd_valid;
      for (int c = 0; c < 25; c++) begin
         step();
         if (cmd_valid && !pv && cmd_op != 3'd1) ops.push_back(int'(cmd_op));
         pv = cmd_valid;
      end
      n_checks++; if (ops.size() != 2) begin n_fail++; $display("FAIL lr_count: got %0d want 2", ops.size()); end
      else begin
         n_checks++; if (ops[0] != 4 || ops[1] != 2) begin n_fail++; $display("FAIL lr_order: got %0d,%0d want 4,2", ops[0], ops[1]); end
      end
      n_checks++; if (pending[3:1] !== 3'b000) begin n_fail++; $display("FAIL lr_pending: got %b want 000x", pending); end
   endtask

   task automatic test_drop();
      bit found = 0;
      int last = -1, prev = -1, rises = 0;
      bit pv;
      sw_drop = 1; step();
      for (int i = 0; i < 25; i++) begin
         step();
         if (m_cnt == 7) begin found = 1; break; end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL drop_sync: got timeout want cnt=7"); end
      sw_drop = 0; eng_blocked = 1;
      step();
      n_checks++; if (fast_mode !== 1'b1) begin n_fail++; $display("FAIL drop_fast: got %b want 1", fast_mode); end
      step();
      n_checks++; if (pending[0] !== 1'b1) begin n_fail++; $display("FAIL drop_tick: got %b want 1", pending[0]); end
      found = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (lock_event === 1'b1) begin found = 1; break; end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL drop_lock: got timeout want lock pulse"); end
      n_checks++; if (fast_mode !== 1'b0) begin n_fail++; $display("FAIL drop_fastclr: got %b want 0", fast_mode); end
      eng_blocked = 0;
      step();
      n_checks++; if (lock_event !== 1'b0) begin n_fail++; $display("FAIL drop_lockwidth: got %b want 0", lock_event); end
      pv = cmd_valid;
      for (int c = 0; c < 30; c++) begin
         step();
         if (cmd_valid && !pv) begin prev = last; last = c; rises++; end
         pv = cmd_valid;
      end
      n_checks++; if (rises < 2 || last - prev != FALL) begin n_fail++; $display("FAIL drop_period_back: got %0d want %0d", last - prev, FALL); end
   endtask

   task automatic test_ready_hold();
      int lefts = 0;
      bit pv;
      auto_eng = 0; cmd_ready = 1; cmd_done = 0; btn_left = 1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (m_phase == 0) break;
         cmd_done = (m_phase == 2);
      end
      cmd_done = 0; enable = 0;
      step();
      enable = 1; btn_left = 0; cmd_ready = 0;
      step(); step();
      n_checks++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd2) begin n_fail++; $display("FAIL hold_issue: got v=%b op=%0d want v=1 op=2", cmd_valid, cmd_op); end
      for (int c = 0; c < 20; c++) begin
         step();
         n_checks++; if (cmd_valid !== 1'b1 || cmd_op !== 3'd2) begin n_fail++; $display("FAIL hold_stable: got v=%b op=%0d want v=1 op=2", cmd_valid, cmd_op); end
         if (c == 6) begin
            n_checks++; if (pending[1] !== 1'b1) begin n_fail++; $display("FAIL hold_pend_left: got %b want 1", pending[1]); end
         end
         if (c % 6 == 2) btn_left = 1;
         if (c % 6 == 4) btn_left = 0;
      end
      auto_eng = 1; eng_cd = 0; pv = 1;
      for (int c = 0; c < 30; c++) begin
         step();
         if (cmd_valid && !pv && cmd_op == 3'd2) lefts++;
         pv = cmd_valid;
      end
      n_checks++; if (lefts != 1) begin n_fail++; $display("FAIL hold_one_more: got %0d want 1", lefts); end
   endtask

   task automatic test_enable_wait();
      bit found = 0;
      bit pv = 0;
      int first = -1;
      auto_eng = 0; cmd_ready = 1; cmd_done = 0; btn_left = 1; btn_rotate = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (m_phase == 2) begin found = 1; break; end
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL ew_wait: got timeout want WAIT"); end
      btn_left = 0; btn_rotate = 0;
      step();
      for (int i = 0; i < 15; i++) begin
         if (m_pend[0]) break;
         step();
      end
      n_checks++; if (pending !== 4'b1011) begin n_fail++; $display("FAIL ew_pending: got %b want 1011", pending); end
      enable = 0;
      step();
      n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL ew_clear: got %b want 0000", pending); end
      cmd_done = 1;
      step();
      cmd_done = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL ew_noissue: got %b want 0", cmd_valid); end
      end
      enable = 1; auto_eng = 1; eng_cd = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         if (cmd_valid && !pv && first < 0) first = c;
         pv = cmd_valid;
      end
      n_checks++; if (first != 10) begin n_fail++; $display("FAIL ew_timer_zero: got cycle %0d want 10", first); end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      bit seen = 0;
      auto_eng = 0; cmd_ready = 0; cmd_done = 0; btn_right = 1; enable = 1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (m_phase == 1) begin found = 1; break; end
         cmd_done = (m_phase == 2);
      end
      n_checks++; if (!found || cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rm_issue: got v=%b want 1", cmd_valid); end
      cmd_done = 0; rst = 1;
      step();
      n_checks++; if ({cmd_valid, cmd_op, fast_mode, pending, lock_event} !== 10'd0) begin
         n_fail++; $display("FAIL rm_outputs: got v=%b op=%0d f=%b p=%b l=%b want all 0", cmd_valid, cmd_op, fast_mode, pending, lock_event);
      end
      rst = 0; auto_eng = 1; eng_cd = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         if (cmd_valid && cmd_op == 3'd3) seen = 1;
      end
      n_checks++; if (seen) begin n_fail++; $display("FAIL rm_held: got RIGHT issued want none"); end
      btn_right = 0;
      for (int c = 0; c < 25; c++) begin
         step();
         if (cmd_valid && cmd_op == 3'd3) seen = 1;
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL rm_release: got no RIGHT want RIGHT"); end
   endtask

   task automatic test_random();
      auto_eng = 0;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         step();
         n_checks++; if (cmd_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", c, cmd_valid, m_valid); end
         n_checks++; if (cmd_op !== 3'(m_op)) begin n_fail++; $display("FAIL rnd_op@%0d: got %0d want %0d", c, cmd_op, m_op); end
         n_checks++; if (pending !== m_pend) begin n_fail++; $display("FAIL rnd_pending@%0d: got %b want %b", c, pending, m_pend); end
         n_checks++; if (fast_mode !== m_fast) begin n_fail++; $display("FAIL rnd_fast@%0d: got %b want %b", c, fast_mode, m_fast); end
         n_checks++; if (lock_event !== m_lock) begin n_fail++; $display("FAIL rnd_lock@%0d: got %b want %b", c, lock_event, m_lock); end
         rst = ($urandom % 300) == 0;
         enable = ($urandom % 40) != 0;
         if ($urandom % 4 == 0) btn_left = ~btn_left;
         if ($urandom % 4 == 0) btn_right = ~btn_right;
         if ($urandom % 4 == 0) btn_rotate = ~btn_rotate;
         if ($urandom % 6 == 0) sw_drop = ~sw_drop;
         cmd_ready = $urandom % 2;
         cmd_done = ($urandom % 3) == 0;
         cmd_blocked = $urandom % 2;
      end
   endtask

   initial begin
      rst = 1; enable = 0; btn_left = 0; btn_right = 0; btn_rotate = 0; sw_drop = 0;
      cmd_ready = 0; cmd_done = 0; cmd_blocked = 0;
      test_reset();
      test_gravity();
      test_left_rotate();
      test_drop();
      test_ready_hold();
      test_enable_wait();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/tetris_move_sched.md
Name: tetris_move_sched

Overview:
Sequences all piece-motion commands into the playfield engine. It generates the gravity tick with a normal or fast-drop period and turns button releases into latched requests. It arbitrates the pending requests by fixed priority and issues one command at a time over a valid/ready/done handshake. It sits between the board I/O and the playfield/collision datapath, and reports piece-lock events to the score and spawn logic.

Parameters:
FALL_PERIOD, 50000000, gravity period in clk cycles, normal mode
DROP_PERIOD, 5000000, gravity period in clk cycles, fast-drop mode; must be less than FALL_PERIOD
CNT_W, 26, timer width; 2^CNT_W must exceed FALL_PERIOD

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
enable  in  1  game running; when low, no new requests are accepted
btn_left  in  1  left button, level
btn_right  in  1  right button, level
btn_rotate  in  1  rotate button, level
sw_drop  in  1  drop switch, level
cmd_valid  out  1  command offered to the playfield engine
cmd_op  out  3  command code: 0 NONE, 1 FALL, 2 LEFT, 3 RIGHT, 4 ROTATE
cmd_ready  in  1  engine accepts the command
cmd_done  in  1  one-cycle pulse when the engine finishes the command
cmd_blocked  in  1  valid with cmd_done; the move collided and was reverted
fast_mode  out  1  fast-drop active
pending  out  4  pending flags {rotate, right, left, fall}
lock_event  out  1  one-cycle pulse when a FALL command completes blocked (piece locked)

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE, the timer goes to 0, and all input history registers go to 0.
- Input events: each input is registered once per cycle.
  - An event fires on a falling edge (previous=1, current=0), i.e. on release.
  - A button held through reset produces no event until it is released after reset.
- Drop: a falling edge on sw_drop while enable=1 sets fast_mode. fast_mode clears on lock_event or when enable=0.
- Gravity timer:
  - Counts while enable=1; held at 0 while enable=0.
  - Period P = DROP_PERIOD when fast_mode=1, else FALL_PERIOD.
  - Tick fires when cnt >= P-1; cnt wraps to 0 on the same edge.
  - Switching to fast mode with cnt above DROP_PERIOD-1 therefore ticks on the next cycle.
- Pending flags:
  - Set by their own event (tick sets fall) while enable=1.
  - Cleared when the matching op is selected.
  - If a set and a clear hit the same flag in the same cycle, set wins.
  - A repeated event on an already-set flag is absorbed; there is no counting.
  - enable=0 clears all pending flags.
- FSM (IDLE, ISSUE, WAIT):
  - IDLE: if enable=1 and any flag is pending, select by priority FALL > ROTATE > LEFT > RIGHT. Register cmd_op, clear the selected flag, assert cmd_valid, go to ISSUE. A flag set in cycle N yields cmd_valid in cycle N+1.
  - ISSUE: cmd_valid and cmd_op are held stable until cmd_ready=1. On that edge cmd_valid drops to 0 and the FSM goes to WAIT. cmd_op keeps its value.
  - WAIT: on cmd_done, if cmd_op=FALL and cmd_blocked=1, pulse lock_event for one cycle. Then return to IDLE and set cmd_op to 0.
  - Earliest re-issue is the cycle after the return to IDLE.
  - Left and right both pending: both are issued, left first.
- enable falling mid-command: the ISSUE/WAIT handshake runs to completion (the engine is never abandoned). Only new issue is blocked.
- cmd_ready or cmd_done outside the expected state: ignored.
- rst mid-command: immediate return to the reset state. cmd_valid is low the cycle after rst is sampled.
- pending output is the live flag vector. All outputs are registered.

Test Plan:
- FALL_PERIOD=10, DROP_PERIOD=3, enable=1, cmd_ready tied 1, cmd_done 2 cycles after accept -> cmd_valid with cmd_op=1 every 10 cycles; fast_mode=0.
- Release btn_left and btn_rotate in the same cycle, ready tied 1 -> cmd_op sequence 4 then 2, one command per handshake; pending returns to 0000.
- sw_drop 1->0 with timer cnt=7 -> tick next cycle, then period 3. FALL done with cmd_blocked=1 -> lock_event high exactly 1 cycle, fast_mode=0, period back to 10.
- Hold cmd_ready=0 for 20 cycles while 3 left releases occur -> cmd_valid and cmd_op=2 stable throughout, pending[1]=1 after the first issue. After ready and done -> exactly one more LEFT issued.
- Drop enable during WAIT with pending=1011 -> pending clears next cycle, cmd_done still returns the FSM to IDLE, no further cmd_valid, timer stays 0.
- Assert rst during ISSUE with btn_right held at 1 -> all outputs 0 next cycle; no RIGHT event until btn_right is released.
